// File: rtl/computer_system_pio_pkg.sv
// Shared PIO definitions: register offsets and edge-capture mode codes.
// Used by the input/output PIOs and mirrored by the HPS header generator.
`timescale 1ns/1ps
package computer_system_pio_pkg;

    // Word offsets within a PIO slave
    localparam logic [1:0] PIO_DATA    = 2'd0;
    localparam logic [1:0] PIO_IRQMASK = 2'd1;
    localparam logic [1:0] PIO_EDGECAP = 2'd2;
    localparam logic [1:0] PIO_RSVD    = 2'd3;

    // Edge-capture mode codes for input PIOs
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_bit_sync.sv
// Multi-flop synchroniser for a bus of independent asynchronous bits.
// Each bit is synchronised on its own; no cross-bit coherency is implied.
`timescale 1ns/1ps
module pio_bit_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] synced
);

    logic [WIDTH-1:0] chain [STAGES];

    // Shift the raw inputs through STAGES flops; reset clears every stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= raw;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign synced = chain[STAGES-1];

endmodule

// File: rtl/fpga_status_in_pio.sv
// Avalon-MM input PIO: synchronised status inputs, per-bit sticky edge
// capture with write-1-to-clear, and a maskable level interrupt.
`timescale 1ns/1ps
module fpga_status_in_pio
    import computer_system_pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int CNT_W = $clog2(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0] PRIME_MAX = CNT_W'(SYNC_STAGES);

    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] raw_det;
    logic [WIDTH-1:0] det;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecap;
    logic [WIDTH-1:0] wr_bits;
    logic [WIDTH-1:0] clr;
    logic [CNT_W-1:0] prime_cnt;
    logic             primed;
    logic             wr_en;

    pio_bit_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst    (reset),
        .raw    (in_port),
        .synced (s)
    );

    assign wr_en   = chipselect & ~write_n;
    assign wr_bits = writedata[WIDTH-1:0];

    generate
        if (WIDTH < 32) begin : g_unused_wd
            logic unused_wd;
            assign unused_wd = ^writedata[31:WIDTH];
        end
    endgenerate

    // Previous synchronised value for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev <= '0;
        end else begin
            prev <= s;
        end
    end

    // Priming: count SYNC_STAGES cycles to fill the chain, then enable
    // detection one cycle later, once prev also holds a real sample
    // rather than the reset zero (avoids a capture for inputs held high).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prime_cnt <= '0;
            primed    <= 1'b0;
        end else begin
            if (prime_cnt != PRIME_MAX) begin
                prime_cnt <= prime_cnt + CNT_W'(1);
            end
            primed <= (prime_cnt == PRIME_MAX);
        end
    end

    generate
        if (EDGE_TYPE == EDGE_RISE) begin : g_rise
            assign raw_det = s & ~prev;
        end else if (EDGE_TYPE == EDGE_FALL) begin : g_fall
            assign raw_det = ~s & prev;
        end else begin : g_any
            assign raw_det = s ^ prev;
        end
    endgenerate

    assign det = primed ? raw_det : '0;
    assign clr = (wr_en && address == PIO_EDGECAP) ? wr_bits : '0;

    // Interrupt mask register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irqmask <= '0;
        end else if (wr_en && address == PIO_IRQMASK) begin
            irqmask <= wr_bits;
        end
    end

    // Sticky edge flags; a new edge wins over a simultaneous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edgecap <= '0;
        end else begin
            edgecap <= (edgecap & ~clr) | det;
        end
    end

    // Zero-wait-state read mux, zero-extended to the bus width
    always_comb begin
        readdata = '0;
        case (address)
            PIO_DATA:    readdata[WIDTH-1:0] = s;
            PIO_IRQMASK: readdata[WIDTH-1:0] = irqmask;
            PIO_EDGECAP: readdata[WIDTH-1:0] = edgecap;
            default:     readdata = '0;
        endcase
    end

    assign irq = |(edgecap & irqmask);

endmodule
